// File: rtl/noc_pkg.sv
// Shared NoC tree definitions: packet layout, port index, merge FSM states,
// plus the address constants used by the 1-to-2 decoder.
package noc_pkg;

  localparam int PKT_W   = 9;
  localparam int ADDR_HI = 8;
  localparam int ADDR_LO = 5;
  localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;

  // Decoder steering: packets whose masked address nibble matches go to Out1
  localparam logic [ADDR_W-1:0] DEC_ADDR_MASK  = 4'h8;
  localparam logic [ADDR_W-1:0] DEC_ADDR_MATCH = 4'h8;

  typedef logic [PKT_W-1:0] pkt_t;
  typedef logic             port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } merge_state_t;

  function automatic logic [ADDR_W-1:0] pkt_addr(input pkt_t p);
    return p[ADDR_HI:ADDR_LO];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: combinational winner plus the registered
// priority bit, which moves to the loser only when a packet is accepted.
module rr_arb2
  import noc_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic      CLK,
  input  logic      _RESET,
  input  logic      req0,
  input  logic      req1,
  input  logic      advance,
  output port_idx_t winner
);

  logic prio;

  // A lone requester always wins; a tie goes to the priority holder
  always_comb begin
    winner = prio;
    if (req0 && !req1)
      winner = 1'b0;
    else if (req1 && !req0)
      winner = 1'b1;
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET)
      prio <= (RR_INIT != 0);
    else if (advance)
      prio <= ~winner;
  end

endmodule

// File: rtl/merge_arb2.sv
// Fair 2-to-1 packet merge for the NoC return path; emits a grant token
// per packet naming the winning input, ordered with the Out stream.
module merge_arb2
  import noc_pkg::*;
#(
  parameter int WIDTH      = PKT_W,
  parameter int RR_INIT    = 0,
  parameter bit EMIT_GRANT = 1'b1
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             In0_valid,
  output logic             In0_ready,
  input  logic [WIDTH-1:0] In0_data,
  input  logic             In1_valid,
  output logic             In1_ready,
  input  logic [WIDTH-1:0] In1_data,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Out_data,
  output logic             G_valid,
  input  logic             G_ready,
  output logic             G_data
);

  merge_state_t state;
  port_idx_t    winner;
  logic         out_done, g_done;
  logic         accept, out_fire, g_fire, out_ok, g_ok;

  assign accept    = _RESET && (state == IDLE) && (In0_valid || In1_valid);
  assign In0_ready = accept && (winner == 1'b0);
  assign In1_ready = accept && (winner == 1'b1);

  assign out_fire = Out_valid && Out_ready;
  assign g_fire   = G_valid && G_ready;
  assign out_ok   = out_done || out_fire;
  assign g_ok     = !EMIT_GRANT || g_done || g_fire;

  rr_arb2 #(
    .RR_INIT(RR_INIT)
  ) u_arb (
    .CLK    (CLK),
    ._RESET (_RESET),
    .req0   (In0_valid),
    .req1   (In1_valid),
    .advance(accept),
    .winner (winner)
  );

  // Out and G drain independently; the slot frees only once both are done
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state     <= IDLE;
      Out_valid <= 1'b0;
      G_valid   <= 1'b0;
      Out_data  <= '0;
      G_data    <= 1'b0;
      out_done  <= 1'b0;
      g_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            Out_data  <= winner ? In1_data : In0_data;
            G_data    <= winner;
            Out_valid <= 1'b1;
            G_valid   <= EMIT_GRANT;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_fire) begin
            Out_valid <= 1'b0;
            out_done  <= 1'b1;
          end
          if (g_fire) begin
            G_valid <= 1'b0;
            g_done  <= 1'b1;
          end
          if (out_ok && g_ok) begin
            state    <= IDLE;
            out_done <= 1'b0;
            g_done   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Upstream must hold a raised valid and its data until the handshake
  assert property (@(posedge CLK) disable iff (!_RESET)
    (In0_valid && !In0_ready) |=> (In0_valid && $stable(In0_data)));
  assert property (@(posedge CLK) disable iff (!_RESET)
    (In1_valid && !In1_ready) |=> (In1_valid && $stable(In1_data)));
  assert property (@(posedge CLK) disable iff (!_RESET)
    !(In0_ready && In1_ready));

endmodule

// File: tb/tb_merge_arb2.sv
// Bench for merge_arb2: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model of the merge (FIFO of pending tokens).
module tb_merge_arb2;
  import noc_pkg::*;

  logic CLK = 1'b0;
  logic _RESET;
  always #5 CLK = ~CLK;

  logic in_valid [2][2];
  logic in_ready [2][2];
  pkt_t in_data  [2][2];
  logic out_valid[2];
  logic out_ready[2];
  pkt_t out_data [2];
  logic g_valid  [2];
  logic g_ready  [2];
  logic g_data   [2];

  merge_arb2 #(.WIDTH(PKT_W), .RR_INIT(0), .EMIT_GRANT(1'b1)) dut0 (
    .CLK(CLK), ._RESET(_RESET),
    .In0_valid(in_valid[0][0]), .In0_ready(in_ready[0][0]), .In0_data(in_data[0][0]),
    .In1_valid(in_valid[0][1]), .In1_ready(in_ready[0][1]), .In1_data(in_data[0][1]),
    .Out_valid(out_valid[0]), .Out_ready(out_ready[0]), .Out_data(out_data[0]),
    .G_valid(g_valid[0]), .G_ready(g_ready[0]), .G_data(g_data[0])
  );

  merge_arb2 #(.WIDTH(PKT_W), .RR_INIT(0), .EMIT_GRANT(1'b0)) dut1 (
    .CLK(CLK), ._RESET(_RESET),
    .In0_valid(in_valid[1][0]), .In0_ready(in_ready[1][0]), .In0_data(in_data[1][0]),
    .In1_valid(in_valid[1][1]), .In1_ready(in_ready[1][1]), .In1_data(in_data[1][1]),
    .Out_valid(out_valid[1]), .Out_ready(out_ready[1]), .Out_data(out_data[1]),
    .G_valid(g_valid[1]), .G_ready(g_ready[1]), .G_data(g_data[1])
  );

  pkt_t src[2][2][0:63];
  int   s_head[2][2], s_tail[2][2];
  bit   offered[2][2];
  pkt_t exp_out[2][0:63];
  int   eo_h[2], eo_t[2];
  bit   exp_g[2][0:63];
  int   eg_h[2], eg_t[2];
  bit   prio_m[2];
  pkt_t log_out[2][0:127];
  int   n_log[2];
  bit   log_g[0:127];
  int   n_glog;
  int   offer_pct, ordy_mode, grdy_mode;
  int   n_asserts, n_fail;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int i, input pkt_t p);
    src[d][i][s_tail[d][i]] = p;
    s_tail[d][i]++;
  endtask

  function automatic bit pending(input int d);
    return (s_head[d][0] < s_tail[d][0]) || (s_head[d][1] < s_tail[d][1]) ||
           offered[d][0] || offered[d][1] || (eo_h[d] != eo_t[d]) || (eg_h[d] != eg_t[d]);
  endfunction

  // One cycle: drive at negedge, compare just after, then advance the model
  task automatic step(input int d);
    bit er[2];
    bit free;
    int w;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      if (!offered[d][i] && s_head[d][i] < s_tail[d][i] && $urandom_range(99) < offer_pct)
        offered[d][i] = 1'b1;
      in_valid[d][i] = offered[d][i];
      in_data[d][i]  = offered[d][i] ? src[d][i][s_head[d][i]] : '0;
    end
    out_ready[d] = (ordy_mode == 2) ? logic'($urandom_range(1)) : (ordy_mode == 1);
    g_ready[d]   = (grdy_mode == 2) ? logic'($urandom_range(1)) : (grdy_mode == 1);
    #1;
    free  = (eo_h[d] == eo_t[d]) && (eg_h[d] == eg_t[d]);
    w     = (offered[d][0] && offered[d][1]) ? int'(prio_m[d]) : (offered[d][1] ? 1 : 0);
    er[0] = free && offered[d][0] && (w == 0);
    er[1] = free && offered[d][1] && (w == 1);
    check("in0_ready", in_ready[d][0], er[0]);
    check("in1_ready", in_ready[d][1], er[1]);
    check("out_valid", out_valid[d], eo_h[d] != eo_t[d]);
    if (eo_h[d] != eo_t[d]) check("out_data", out_data[d], exp_out[d][eo_h[d]]);
    check("g_valid", g_valid[d], eg_h[d] != eg_t[d]);
    if (eg_h[d] != eg_t[d]) check("g_data", g_data[d], exp_g[d][eg_h[d]]);
    if (out_valid[d] === 1'b1 && out_ready[d]) begin
      log_out[d][n_log[d]] = out_data[d];
      n_log[d]++;
    end
    if (d == 0 && g_valid[0] === 1'b1 && g_ready[0]) begin
      log_g[n_glog] = g_data[0];
      n_glog++;
    end
    if (eo_h[d] != eo_t[d] && out_ready[d]) eo_h[d]++;
    if (eg_h[d] != eg_t[d] && g_ready[d]) eg_h[d]++;
    if (er[0] || er[1]) begin
      exp_out[d][eo_t[d]] = src[d][w][s_head[d][w]];
      eo_t[d]++;
      if (d == 0) begin
        exp_g[d][eg_t[d]] = (w == 1);
        eg_t[d]++;
      end
      prio_m[d] = (w == 0);
      s_head[d][w]++;
      offered[d][w] = 1'b0;
    end
  endtask

  task automatic drain(input int d, input int budget);
    int c = 0;
    while (pending(d) && c < budget) begin
      step(d);
      c++;
    end
    check("drain_done", pending(d), 1'b0);
  endtask

  // Asynchronous reset landing between edges; outputs must clear at once
  task automatic reset_all();
    @(negedge CLK);
    #3;
    _RESET = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2; i++) begin
        s_head[d][i] = 0; s_tail[d][i] = 0; offered[d][i] = 1'b0;
        in_valid[d][i] = 1'b0; in_data[d][i] = '0;
      end
      eo_h[d] = 0; eo_t[d] = 0; eg_h[d] = 0; eg_t[d] = 0;
      prio_m[d] = 1'b0; n_log[d] = 0;
    end
    n_glog = 0;
    in_valid[0][0] = 1'b1;
    in_data[0][0]  = 9'h155;
    #1;
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_g_valid", g_valid[0], 1'b0);
    check("rst_out_data", out_data[0], 9'h000);
    check("rst_g_data", g_data[0], 1'b0);
    check("rst_in0_ready", in_ready[0][0], 1'b0);
    check("rst_in1_ready", in_ready[0][1], 1'b0);
    check("rst_dut1_out_valid", out_valid[1], 1'b0);
    @(negedge CLK);
    in_valid[0][0] = 1'b0;
    @(negedge CLK);
    _RESET = 1'b1;
  endtask

  initial begin
    int n;
    int ng;
    n_asserts = 0; n_fail = 0;
    offer_pct = 100; ordy_mode = 1; grdy_mode = 1;
    _RESET = 1'b0;
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b0; g_ready[d] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        in_valid[d][i] = 1'b0; in_data[d][i] = '0;
      end
    end
    reset_all();

    // Single source, back-to-back packets spaced by the two-cycle slot
    push(0, 0, 9'h1A5);
    push(0, 0, 9'h1A6);
    drain(0, 20);
    check("single_count", n_log[0], 2);
    check("single_data0", log_out[0][0], 9'h1A5);
    check("single_g0", log_g[0], 1'b0);
    check("single_data1", log_out[0][1], 9'h1A6);

    // Continuous contention alternates starting from input 0
    reset_all();
    push(0, 0, 9'h101); push(0, 0, 9'h102);
    push(0, 1, 9'h0A1); push(0, 1, 9'h0A2);
    drain(0, 30);
    check("cont_count", n_log[0], 4);
    check("cont_out0", log_out[0][0], 9'h101);
    check("cont_out1", log_out[0][1], 9'h0A1);
    check("cont_out2", log_out[0][2], 9'h102);
    check("cont_out3", log_out[0][3], 9'h0A2);
    check("cont_g0", log_g[0], 1'b0);
    check("cont_g1", log_g[1], 1'b1);
    check("cont_g2", log_g[2], 1'b0);
    check("cont_g3", log_g[3], 1'b1);

    // Backpressure: accept, then ten stalled cycles, then a single release
    push(0, 0, 9'h111);
    push(0, 1, 9'h0B1);
    ordy_mode = 0;
    for (int k = 0; k < 11; k++) step(0);
    n = n_log[0];
    ordy_mode = 1;
    step(0);
    step(0);
    check("bp_one_release", n_log[0], n + 1);
    check("bp_first_pkt", log_out[0][n], 9'h111);
    drain(0, 30);

    // Split completion: grant drains first, Out stalls
    n = n_log[0];
    ng = n_glog;
    push(0, 0, 9'h1C3);
    ordy_mode = 0;
    for (int k = 0; k < 4; k++) step(0);
    check("split_g_once", n_glog, ng + 1);
    check("split_no_out", n_log[0], n);
    ordy_mode = 1;
    drain(0, 20);
    check("split_g_still_once", n_glog, ng + 1);
    check("split_out_once", n_log[0], n + 1);

    // Reset while holding a packet, then normal operation from RR_INIT
    push(0, 1, 9'h0D4);
    ordy_mode = 0; grdy_mode = 0;
    step(0);
    step(0);
    reset_all();
    ordy_mode = 1; grdy_mode = 1;
    push(0, 0, 9'h1E0);
    push(0, 1, 9'h0E0);
    drain(0, 20);
    check("post_rst_count", n_log[0], 2);
    check("post_rst_out0", log_out[0][0], 9'h1E0);
    check("post_rst_out1", log_out[0][1], 9'h0E0);

    // Random traffic with random backpressure on both channels
    reset_all();
    for (int k = 0; k < 12; k++) begin
      push(0, 0, pkt_t'($urandom_range(511)));
      push(0, 1, pkt_t'($urandom_range(511)));
    end
    offer_pct = 60; ordy_mode = 2; grdy_mode = 2;
    drain(0, 600);
    check("rand_count", n_log[0], 24);

    // Grant channel tied off: only Out gates the slot
    for (int k = 0; k < 10; k++) begin
      push(1, 0, pkt_t'($urandom_range(511)));
      push(1, 1, pkt_t'($urandom_range(511)));
    end
    drain(1, 600);
    check("nogrant_count", n_log[1], 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
